// File: rtl/tag_pool_mp.sv
// Free-tag pool for rename/dispatch: FWFT allocation of one tag per cycle,
// up to NUM_REL CDB releases per cycle, checked against an ownership bitmap.
module tag_pool_mp #(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned NUM_REL = 2
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_flush,
    input  logic                               i_alloc_rdy,
    output logic                               o_alloc_valid,
    output logic [$clog2(DEPTH)-1:0]           o_alloc_tag,
    input  logic [NUM_REL-1:0]                 i_rel_valid,
    input  logic [NUM_REL*$clog2(DEPTH)-1:0]   i_rel_tag,
    output logic [$clog2(DEPTH):0]             o_count,
    output logic                               o_empty,
    output logic                               o_full,
    input  logic                               i_err_clr,
    output logic                               o_err
);

    localparam int unsigned TAG_W = $clog2(DEPTH);
    localparam int unsigned CW    = TAG_W + 1;

    logic [TAG_W-1:0] mem [DEPTH];
    logic [TAG_W-1:0] rp;
    logic [TAG_W-1:0] wp;
    logic [CW-1:0]    cnt;
    logic [DEPTH-1:0] free_map;
    logic             err;

    logic             pop;
    logic [TAG_W-1:0] pop_tag;
    logic [TAG_W-1:0] rel_tag [NUM_REL];
    logic [TAG_W-1:0] wr_off  [NUM_REL];
    logic [NUM_REL-1:0] acc;
    logic [CW-1:0]    n_acc;
    logic             dup;
    logic             any_reject;
    logic [DEPTH-1:0] free_nxt;

    always_comb begin
        pop        = i_alloc_rdy && (cnt != '0);
        pop_tag    = mem[rp];
        n_acc      = '0;
        any_reject = 1'b0;
        dup        = 1'b0;
        acc        = '0;
        for (int unsigned k = 0; k < NUM_REL; k++) begin
            rel_tag[k] = i_rel_tag[k*TAG_W +: TAG_W];
            wr_off[k]  = TAG_W'(n_acc);
            // A port is a duplicate only against lower ports that were themselves accepted
            dup = 1'b0;
            for (int unsigned j = 0; j < k; j++) begin
                if (acc[j] && (rel_tag[j] == rel_tag[k])) dup = 1'b1;
            end
            acc[k] = i_rel_valid[k] && !free_map[rel_tag[k]]
                     && !(pop && (rel_tag[k] == pop_tag)) && !dup;
            if (i_rel_valid[k] && !acc[k]) any_reject = 1'b1;
            if (acc[k]) n_acc = n_acc + CW'(1);
        end
    end

    always_comb begin
        free_nxt = free_map;
        if (pop) free_nxt[pop_tag] = 1'b0;
        for (int unsigned k = 0; k < NUM_REL; k++) begin
            if (acc[k]) free_nxt[rel_tag[k]] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= TAG_W'(i);
            rp       <= '0;
            wp       <= '0;
            cnt      <= CW'(DEPTH);
            free_map <= '1;
            err      <= 1'b0;
        end else if (i_flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= TAG_W'(i);
            rp       <= '0;
            wp       <= '0;
            cnt      <= CW'(DEPTH);
            free_map <= '1;
        end else begin
            if (pop) rp <= rp + TAG_W'(1);
            for (int unsigned k = 0; k < NUM_REL; k++) begin
                if (acc[k]) mem[wp + wr_off[k]] <= rel_tag[k];
            end
            wp       <= wp + TAG_W'(n_acc);
            cnt      <= cnt - CW'(pop) + n_acc;
            free_map <= free_nxt;
            err      <= (err & ~i_err_clr) | any_reject;
        end
    end

    assign o_alloc_valid = (cnt != '0);
    assign o_alloc_tag   = mem[rp];
    assign o_count       = cnt;
    assign o_empty       = (cnt == '0);
    assign o_full        = (cnt == CW'(DEPTH));
    assign o_err         = err;

endmodule

// File: tb/tb_tag_pool_mp.sv
// Directed bench for tag_pool_mp (DEPTH=64, NUM_REL=2) with hand-computed expectations.
module tb_tag_pool_mp;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_flush;
    logic        i_alloc_rdy;
    logic        o_alloc_valid;
    logic [5:0]  o_alloc_tag;
    logic [1:0]  i_rel_valid;
    logic [11:0] i_rel_tag;
    logic [6:0]  o_count;
    logic        o_empty;
    logic        o_full;
    logic        i_err_clr;
    logic        o_err;

    int n_cmp  = 0;
    int n_fail = 0;

    tag_pool_mp #(.DEPTH(64), .NUM_REL(2)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_flush       (i_flush),
        .i_alloc_rdy   (i_alloc_rdy),
        .o_alloc_valid (o_alloc_valid),
        .o_alloc_tag   (o_alloc_tag),
        .i_rel_valid   (i_rel_valid),
        .i_rel_tag     (i_rel_tag),
        .o_count       (o_count),
        .o_empty       (o_empty),
        .o_full        (o_full),
        .i_err_clr     (i_err_clr),
        .o_err         (o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic rel(input logic [1:0] v, input logic [5:0] t0, input logic [5:0] t1);
        i_rel_valid = v;
        i_rel_tag   = {t1, t0};
    endtask

    task automatic pool(input string name, input int cnt, input int tag, input int err);
        check({name, ".count"}, 32'(o_count), cnt);
        check({name, ".valid"}, 32'(o_alloc_valid), (cnt != 0) ? 1 : 0);
        check({name, ".empty"}, 32'(o_empty), (cnt == 0) ? 1 : 0);
        check({name, ".full"},  32'(o_full), (cnt == 64) ? 1 : 0);
        check({name, ".err"},   32'(o_err), err);
        if (cnt != 0) check({name, ".tag"}, 32'(o_alloc_tag), tag);
    endtask

    initial begin
        i_rst_n = 1'b0; i_flush = 1'b0; i_alloc_rdy = 1'b0; i_err_clr = 1'b0;
        rel(2'b00, 6'd0, 6'd0);
        #12;
        pool("reset", 64, 0, 0);
        i_rst_n = 1'b1;
        cycle();
        pool("post_reset", 64, 0, 0);

        // first three pops in order
        i_alloc_rdy = 1'b1;
        cycle(); pool("pop1", 63, 1, 0);
        cycle(); pool("pop2", 62, 2, 0);
        cycle(); pool("pop3", 61, 3, 0);

        // drain to empty
        repeat (61) cycle();
        pool("drained", 0, 0, 0);
        cycle();
        pool("pop_on_empty", 0, 0, 0);

        // release 5 while empty and dispatch asking: no bypass
        rel(2'b01, 6'd5, 6'd0);
        #1;
        check("no_bypass.valid", 32'(o_alloc_valid), 0);
        cycle();
        rel(2'b00, 6'd0, 6'd0); i_alloc_rdy = 1'b0;
        pool("rel5", 1, 5, 0);

        // dual release 9/3, order 5,9,3
        rel(2'b11, 6'd9, 6'd3);
        cycle();
        rel(2'b00, 6'd0, 6'd0);
        pool("rel9_3", 3, 5, 0);
        i_alloc_rdy = 1'b1;
        cycle(); pool("fifo_a", 2, 9, 0);
        cycle(); pool("fifo_b", 1, 3, 0);
        cycle(); pool("fifo_c", 0, 0, 0);
        i_alloc_rdy = 1'b0;

        // same tag on both ports: one accepted, error raised
        rel(2'b11, 6'd7, 6'd7);
        cycle();
        rel(2'b00, 6'd0, 6'd0);
        pool("dup7", 1, 7, 1);
        i_err_clr = 1'b1;
        cycle();
        i_err_clr = 1'b0;
        pool("err_clr", 1, 7, 0);

        // release of a free tag with clear asserted: set wins
        i_err_clr = 1'b1;
        rel(2'b01, 6'd7, 6'd0);
        cycle();
        i_err_clr = 1'b0;
        pool("set_wins", 1, 7, 1);

        // release of the tag being popped this cycle is rejected
        i_alloc_rdy = 1'b1;
        cycle();
        i_alloc_rdy = 1'b0;
        rel(2'b00, 6'd0, 6'd0);
        pool("rel_popped", 0, 0, 1);

        // flush holds err, discards a would-be-accepted release
        i_flush = 1'b1;
        rel(2'b01, 6'd3, 6'd0);
        cycle();
        i_flush = 1'b0;
        rel(2'b00, 6'd0, 6'd0);
        pool("flush1", 64, 0, 1);
        i_err_clr = 1'b1;
        cycle();
        i_err_clr = 1'b0;
        pool("clr2", 64, 0, 0);

        // release of free tag 12: dropped, count unchanged
        rel(2'b01, 6'd12, 6'd0);
        cycle();
        rel(2'b00, 6'd0, 6'd0);
        pool("rel_free12", 64, 0, 1);
        i_err_clr = 1'b1;
        cycle();
        i_err_clr = 1'b0;
        pool("clr3", 64, 0, 0);

        // 20 pops, then pop with concurrent dual release
        i_alloc_rdy = 1'b1;
        repeat (20) cycle();
        pool("pop20", 44, 20, 0);
        rel(2'b11, 6'd4, 6'd11);
        cycle();
        pool("pop_and_rel", 45, 21, 0);

        // flush with pop and an illegal release: no error
        i_flush = 1'b1;
        rel(2'b11, 6'd30, 6'd5);
        cycle();
        i_flush = 1'b0;
        rel(2'b00, 6'd0, 6'd0);
        pool("flush2", 64, 0, 0);
        cycle(); pool("after_flush_a", 63, 1, 0);
        cycle(); pool("after_flush_b", 62, 2, 0);
        cycle(); pool("after_flush_c", 61, 3, 0);

        // async reset mid-cycle
        #3;
        i_rst_n = 1'b0;
        #1;
        pool("async_rst", 64, 0, 0);
        i_alloc_rdy = 1'b0;
        #1;
        i_rst_n = 1'b1;
        cycle();
        pool("after_rst", 64, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
